// File: rtl/load_store_unit.sv
// load_store_unit: bridges the core's memory stage to a word-addressed,
// combinational-read data memory. It handles one byte, half or word
// access at a time. Loads extract and extend the addressed lane. Sub-word
// stores read the word, merge the new bytes into it and write it back.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to add the rsp_err output
// and to reject misaligned half/word accesses without touching memory.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. A response transfers on a rising edge where
// rsp_valid and rsp_ready are both 1. rsp_valid/rsp_rdata hold steady
// until that edge, and req_ready stays low from accept to response transfer.
module load_store_unit #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [1:0]  dbg_state
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        rsp_err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]        state;
  logic [MEM_AW+1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [15:0]       wdata_q;
  logic [31:0]       wd_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic [1:0]        req_size;
  logic [1:0]        q_size;
  logic              req_misaligned;

  // Address bits above the memory index are dropped by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

  // Access size. Any code that is not a defined byte/half code is a word.
  function automatic logic [1:0] size_of(input logic we, input logic [2:0] f3);
    logic [1:0] sz;
    sz = SZ_WORD;
    if (we) begin
      case (f3)
        3'b000:  sz = SZ_BYTE;
        3'b001:  sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: sz = SZ_BYTE;
        3'b001, 3'b101: sz = SZ_HALF;
        default:        sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  // Extract the addressed lane. funct3[2] selects zero-extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/half of the base word.
  function automatic logic [31:0] store_merge(input logic [31:0] base,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = base;
    if (size == SZ_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (lane[1]) r[31:16] = wdata;
      else         r[15:0]  = wdata;
    end
    return r;
  endfunction

  assign accept   = req_valid && (state == S_IDLE);
  assign req_size = size_of(req_we, req_funct3);
  assign q_size   = size_of(we_q, f3_q);

  // Misalignment is only detected when the trap feature is built in.
`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_misaligned = 1'b0;
    if (req_size == SZ_HALF) req_misaligned = req_addr[0];
    else if (req_size == SZ_WORD) req_misaligned = (req_addr[1:0] != 2'b00);
  end
`else
  assign req_misaligned = 1'b0;
`endif

  // FSM and datapath registers. Every output comes from these registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= 3'b0;
      we_q    <= 1'b0;
      wdata_q <= 16'b0;
      wd_q    <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= req_addr[MEM_AW+1:0];
            f3_q    <= req_funct3;
            we_q    <= req_we;
            wdata_q <= req_wdata[15:0];
            rdata_q <= 32'b0;
            if (req_misaligned) begin
              state <= S_RESP;
            end else if (req_we && (req_size == SZ_WORD)) begin
              // Full-word store needs no merge base.
              wd_q  <= req_wdata;
              state <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (we_q) begin
            wd_q  <= store_merge(mem_rd, wdata_q, addr_q[1:0], q_size);
            state <= S_WRITE;
          end else begin
            rdata_q <= load_extract(mem_rd, f3_q, addr_q[1:0], q_size);
            state   <= S_RESP;
          end
        end
        S_WRITE: begin
          state <= S_RESP;
        end
        default: begin
          if (rsp_ready) state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  // Error flag for the pending response. It is set only by a rejected access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= req_misaligned;
    end
  end

  assign rsp_err = err_q;
`endif

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;
  assign mem_wr_en = (state == S_WRITE);
  assign mem_wd    = wd_q;
  assign mem_addr  = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
  assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. It models the data memory,
// drives directed and random accesses, and predicts results with a
// byte-level reference model. Build with LSU_MISALIGN_TRAP_EN to cover
// the misalignment trap.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [1:0]  dbg_state;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        rsp_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Results gathered by run_op.
  int          o_lat;
  int          o_wr;
  logic [31:0] o_wd;
  logic [31:0] o_rdata;
  logic        o_err;

  // Memory model and reference copy.
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = 10'd0;
  logic [31:0] pl_data = 32'b0;

  load_store_unit #(.MEM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .dbg_state(dbg_state)
`ifdef LSU_MISALIGN_TRAP_EN
    , .rsp_err(rsp_err)
`endif
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Data memory: combinational read, returns 0 during a write cycle.
  assign mem_rd = mem_wr_en ? 32'b0 : mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[9:0]] <= mem_wd;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int ref_bytes(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic ref_misaligned(input logic we, input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    int n;
    n = ref_bytes(we, f3);
    return (n == 2 && (addr % 2) != 0) || (n == 4 && (addr % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int n;
    n = ref_bytes(1'b0, f3);
    if (n == 1) begin
      v = (word >> (8 * (addr % 4))) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (n == 2) begin
      v = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    int sh;
    int n;
    n = ref_bytes(1'b1, f3);
    if (n == 4) return wdata;
    sh = (n == 1) ? 8 * (addr % 4) : 16 * ((addr / 2) % 2);
    mask = ((n == 1) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((wdata << sh) & mask);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preload(input int idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx[9:0]; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Presents one request. It returns once rsp_valid is seen, with
  // rsp_ready still low.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    bit done;
    int k;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_lat = 0; o_wr = 0; o_wd = 32'b0; done = 0; k = 1;
    while (!done && k <= 8) begin
      if (mem_wr_en === 1'b1) begin o_wr++; o_wd = mem_wd; end
      if (rsp_valid === 1'b1) begin o_lat = k; done = 1; end
      else begin @(posedge clk); #1; k++; end
    end
    o_rdata = rsp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    o_err = rsp_err;
`else
    o_err = 1'b0;
`endif
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: got no rsp_valid within 8 cycles, required one");
    end
  endtask

  // Accepts the response and checks that the block is ready again.
  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL return_idle: got req_ready=%b rsp_valid=%b, required 1/0", req_ready, rsp_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'b0 ||
        mem_addr !== 32'b0 || mem_wr_en !== 1'b0 || mem_wd !== 32'b0) begin
      n_bad++;
      $display("FAIL reset_values: got rdy=%b vld=%b rdata=%h addr=%h we=%b wd=%h, required 1/0/0/0/0/0",
               req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_wd);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
  endtask

  task automatic test_load_byte;
    preload(1, 32'h8000_80F1);
    run_op(1'b0, 3'b000, 32'd4, 32'b0);
    n_cmp++;
    if (o_rdata !== 32'hFFFF_FFF1 || o_lat != 2) begin
      n_bad++; $display("FAIL lb: got %h lat %0d, required FFFFFFF1 lat 2", o_rdata, o_lat);
    end
    finish_rsp();
    run_op(1'b0, 3'b100, 32'd4, 32'b0);
    n_cmp++;
    if (o_rdata !== 32'h0000_00F1 || o_lat != 2) begin
      n_bad++; $display("FAIL lbu: got %h lat %0d, required 000000F1 lat 2", o_rdata, o_lat);
    end
    finish_rsp();
  endtask

  task automatic test_load_half;
    run_op(1'b0, 3'b001, 32'd6, 32'b0);
    n_cmp++;
    if (o_rdata !== 32'hFFFF_8000 || o_lat != 2) begin
      n_bad++; $display("FAIL lh: got %h lat %0d, required FFFF8000 lat 2", o_rdata, o_lat);
    end
    finish_rsp();
`ifndef LSU_MISALIGN_TRAP_EN
    run_op(1'b0, 3'b101, 32'd5, 32'b0);
    n_cmp++;
    if (o_rdata !== 32'h0000_80F1 || o_lat != 2) begin
      n_bad++; $display("FAIL lhu_odd: got %h lat %0d, required 000080F1 lat 2", o_rdata, o_lat);
    end
    finish_rsp();
`endif
  endtask

  task automatic test_store_byte;
    preload(2, 32'h1122_3344);
    run_op(1'b1, 3'b000, 32'd9, 32'h0000_00AB);
    n_cmp++;
    if (o_wr != 1 || o_wd !== 32'h1122_AB44 || o_lat != 3 || o_rdata !== 32'b0) begin
      n_bad++;
      $display("FAIL sb: got wr=%0d wd=%h lat=%0d rdata=%h, required 1/1122AB44/3/0", o_wr, o_wd, o_lat, o_rdata);
    end
    finish_rsp();
    n_cmp++;
    if (mem[2] !== 32'h1122_AB44) begin
      n_bad++; $display("FAIL sb_mem: got %h, required 1122AB44", mem[2]);
    end
    ref_mem[2] = 32'h1122_AB44;
  endtask

  task automatic test_store_word_hold;
    run_op(1'b1, 3'b010, 32'd12, 32'hDEAD_BEEF);
    n_cmp++;
    if (o_wr != 1 || o_lat != 2 || o_wd !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL sw: got wr=%0d lat=%0d wd=%h, required 1/2/DEADBEEF", o_wr, o_lat, o_wd);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'b0 || mem_wr_en !== 1'b0) begin
        n_bad++;
        $display("FAIL sw_hold: got vld=%b rdy=%b rdata=%h we=%b, required 1/0/0/0", rsp_valid, req_ready, rsp_rdata, mem_wr_en);
      end
    end
    finish_rsp();
    n_cmp++;
    if (mem[3] !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL sw_mem: got %h, required DEADBEEF", mem[3]);
    end
    ref_mem[3] = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset_mid_op;
    int pulses;
    pulses = 0;
    preload(5, 32'hCAFE_F00D);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'd20; req_wdata = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_read: got vld=%b rdy=%b we=%b, required 0/1/0", rsp_valid, req_ready, mem_wr_en);
    end
    repeat (2) begin @(posedge clk); #1; if (mem_wr_en === 1'b1) pulses++; end
    reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (mem_wr_en === 1'b1 || rsp_valid === 1'b1) pulses++; end
    n_cmp++;
    if (pulses != 0 || mem[5] !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL reset_no_write: got activity=%0d mem=%h, required 0/CAFEF00D", pulses, mem[5]);
    end
    // Reset during the write cycle: the enable must drop without an edge.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd24; req_wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (mem_wr_en !== 1'b1) begin
      n_bad++; $display("FAIL sw_write_cycle: got mem_wr_en=%b, required 1", mem_wr_en);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_write: got mem_wr_en=%b, required 0", mem_wr_en);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (mem[6] !== ref_mem[6] || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_write_dropped: got mem=%h vld=%b, required %h/0", mem[6], rsp_valid, ref_mem[6]);
    end
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic test_misalign;
    run_op(1'b0, 3'b010, 32'd2, 32'b0);
    n_cmp++;
    if (o_err !== 1'b1 || o_rdata !== 32'b0 || o_lat != 1 || o_wr != 0) begin
      n_bad++; $display("FAIL lw_misaligned: got err=%b rdata=%h lat=%0d wr=%0d, required 1/0/1/0", o_err, o_rdata, o_lat, o_wr);
    end
    finish_rsp();
    run_op(1'b0, 3'b010, 32'd0, 32'b0);
    n_cmp++;
    if (o_err !== 1'b0 || o_rdata !== ref_mem[0] || o_lat != 2) begin
      n_bad++; $display("FAIL lw_aligned: got err=%b rdata=%h lat=%0d, required 0/%h/2", o_err, o_rdata, o_lat, ref_mem[0]);
    end
    finish_rsp();
  endtask
`endif

  task automatic test_random;
    for (int n = 0; n < 200; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [31:0] exp_word;
      logic        mis;
      int          idx;
      int          exp_lat;
      int          exp_wr;
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      idx   = $urandom_range(0, 15);
      addr  = ($urandom_range(0, 3) << 12) | (idx << 2) | $urandom_range(0, 3);
      wdata = $urandom;
      mis   = ref_misaligned(we, f3, addr);
      exp_word = ref_mem[idx];
      exp_rdata = 32'b0;
      exp_wr = 0;
      if (mis) exp_lat = 1;
      else if (!we) begin exp_lat = 2; exp_rdata = ref_load(ref_mem[idx], f3, addr); end
      else begin
        exp_lat = (ref_bytes(1'b1, f3) == 4) ? 2 : 3;
        exp_wr = 1;
        exp_word = ref_store(ref_mem[idx], f3, addr, wdata);
      end
      run_op(we, f3, addr, wdata);
      n_cmp++;
      if (o_lat != exp_lat || o_rdata !== exp_rdata || o_wr != exp_wr || o_err !== mis) begin
        n_bad++;
        $display("FAIL rand_rsp[%0d] we=%b f3=%0d addr=%h: got lat=%0d rdata=%h wr=%0d err=%b, required %0d/%h/%0d/%b",
                 n, we, f3, addr, o_lat, o_rdata, o_wr, o_err, exp_lat, exp_rdata, exp_wr, mis);
      end
      finish_rsp();
      ref_mem[idx] = exp_word;
      n_cmp++;
      if (mem[idx] !== exp_word || mem_addr !== 32'(idx)) begin
        n_bad++;
        $display("FAIL rand_mem[%0d]: got mem=%h mem_addr=%h, required %h/%h", n, mem[idx], mem_addr, exp_word, idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_store_byte();
    test_store_word_hold();
    test_reset_mid_op();
`ifdef LSU_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
